pc_stack: RTL

Parametrised program counter with a hardware return-address stack for the 8-bit microprocessor and its wider derivatives. Each falling edge of CLK it computes the next fetch address: sequential increment, PC-relative branch, absolute jump, subroutine call (push return address), or return (pop). It sits between the instruction decoder, which drives `op` and `addr_in`, and instruction memory, which is addressed by `addr_out`.

---
 rtl/pc_stack_if.sv | 29 ++
 rtl/pc_stack.sv | 93 +++++++++
 2 files changed

// File: rtl/pc_stack_if.sv
// Decoder <-> PC/return-stack bundle: control in, fetch address and stack status out.
interface pc_stack_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
);
  localparam int DW = $clog2(DEPTH+1);

  logic              stall;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;
  logic [DW-1:0]     depth;
  logic              stack_full;
  logic              stack_empty;
  logic              ovf_err;
  logic              unf_err;

  // decoder side
  modport master (
    output stall, op, addr_in,
    input  addr_out, depth, stack_full, stack_empty, ovf_err, unf_err
  );

  // pc_stack side
  modport slave (
    input  stall, op, addr_in,
    output addr_out, depth, stack_full, stack_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack. All state moves on the
// falling edge of CLK so the new fetch address is stable at the rising edge.
module pc_stack #(
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic      CLK,
  input  logic      areset,
  pc_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH+1);
  // storage index width; storage is rounded up to a power of two so the
  // index never needs a range check (extra entries are never addressed)
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [DW-1:0]     dep_q, dep_d, dep_m1;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push;
  logic              full, empty;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic [ADDR_W-1:0] stk [0:(1<<IW)-1];

  assign full   = (dep_q == DW'(DEPTH));
  assign empty  = (dep_q == '0);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign dep_m1 = dep_q - DW'(1);
  assign wr_idx = dep_q[IW-1:0];
  assign rd_idx = dep_m1[IW-1:0];

  // next-state decode of the current op; defaults are the sequential path
  always_comb begin
    pc_d  = pc_inc;
    dep_d = dep_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    case (bus.op)
      OP_BRANCH: pc_d = pc_q + bus.addr_in;
      OP_JUMP:   pc_d = bus.addr_in;
      OP_CALL: begin
        if (full) ovf_d = 1'b1;
        else begin
          push  = 1'b1;
          dep_d = dep_q + DW'(1);
          pc_d  = bus.addr_in;
        end
      end
      OP_RET: begin
        if (empty) unf_d = 1'b1;
        else begin
          dep_d = dep_m1;
          pc_d  = stk[rd_idx];
        end
      end
      default: pc_d = pc_inc;
    endcase
  end

  // PC, depth and sticky errors; reset beats stall, stall freezes everything
  always_ff @(negedge CLK) begin
    if (areset) begin
      pc_q  <= RESET_VEC;
      dep_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q  <= pc_d;
      dep_q <= dep_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // stack storage: contents are don't-care after reset, so no reset here
  always_ff @(negedge CLK) begin
    if (!areset && !bus.stall && push) stk[wr_idx] <= pc_inc;
  end

  assign bus.addr_out    = pc_q;
  assign bus.depth       = dep_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;
endmodule
